meta_intf_wrr_scheduler: RTL
============================

META_INTF_WRR_SCHEDULER -- requirements
Module: meta_intf_wrr_scheduler

Interface
REQ-001 Parameter N_INTERFACES, default N_STRM_AXI, number of requester interfaces; the block SHALL support any value >= 2.
REQ-002 Parameter STYPE, default logic[63:0], payload type of every metaIntf data field.
REQ-003 Parameter WEIGHT_BITS, default 4, width of each per-requester weight (beats per grant).
REQ-004 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1, reset, synchronous and active-high.
REQ-006 Port intf_in, metaIntf.s array [N_INTERFACES], STYPE, requester streams (valid/ready/data).
REQ-007 Port intf_out, metaIntf.m, STYPE, scheduled output stream.
REQ-008 Port out_id, output, $clog2(N_INTERFACES), index of the source of the current intf_out beat; valid when intf_out.valid.
REQ-009 Port cfg_weight, input, N_INTERFACES x WEIGHT_BITS, shadow weight values.
REQ-010 Port cfg_load, input, 1, one-cycle strobe that copies cfg_weight into the active weight registers.

Function
REQ-011 State: active weight array W[i], current grant register cur, credit counter crd (WEIGHT_BITS), one output register slot (data, out_id, valid).
REQ-012 Eligible(i) = intf_in[i].valid AND W[i] != 0; a requester with W[i] == 0 SHALL be disabled, with its ready held low.
REQ-013 Combinational selection sel: cur if crd > 0 AND Eligible(cur); otherwise the first eligible index scanning cur+1, cur+2, ... modulo N_INTERFACES, with cur checked last.
REQ-014 Slot free = NOT intf_out.valid OR intf_out.ready.
REQ-015 intf_in[i].ready SHALL be 1 only when i == sel, some requester is eligible, and the slot is free. At most one ready SHALL be high per cycle.
REQ-016 Transfer = a valid&ready beat on intf_in[sel]. On transfer the slot SHALL load data and out_id = sel and set valid, giving 1-cycle latency.
REQ-017 On transfer with sel == cur, crd SHALL decrement by 1. With sel != cur, or with crd == 0 and sel == cur, the block SHALL set cur <= sel and crd <= W[sel] - 1.
REQ-018 Without a transfer, cur and crd SHALL hold. A granted requester that deasserts valid SHALL lose its grant the next time another eligible requester is selected; its remaining credit is forfeited.
REQ-019 When intf_out.ready is high and no transfer occurs, intf_out.valid SHALL clear. When intf_out.valid is high and intf_out.ready is low, data and out_id SHALL remain stable.
REQ-020 Full throughput: with ready held high and continuous eligible input, one beat SHALL be output every cycle, including across grant switches.
REQ-021 cfg_load SHALL update W on the next edge. An in-progress crd SHALL be unaffected; new weights apply at the next credit reload. cfg_load during a transfer SHALL not disturb that transfer.
REQ-022 Weight W[i] SHALL be interpreted as unsigned beats per grant, 1..2^WEIGHT_BITS-1. crd arithmetic SHALL never underflow.
REQ-023 If no requester is eligible, there SHALL be no transfer, and cur and crd SHALL hold.

Reset
REQ-024 On rst: intf_out.valid=0, out_id=0, cur=N_INTERFACES-1, crd=0, all W[i]=1, all intf_in ready=0 during the reset cycle.
REQ-025 Reset asserted mid-operation SHALL drop any slot contents and all credit. The first grant after reset SHALL go to the lowest-index eligible requester.

Verification
REQ-026 N=4, all W=1, all inputs always valid, out ready=1 -> out_id sequence 0,1,2,3,0,... with one beat per cycle.
REQ-027 N=4, W={3,1,2,1}, all valid, ready=1 -> out_id 0,0,0,1,2,2,3, repeating.
REQ-028 Only input 2 valid, W[2]=2 -> continuous beats from 2 with a reload every 2 beats. When input 0 becomes valid, the switch to 0 occurs once crd reaches 0.
REQ-029 intf_out.ready low for 5 cycles while valid -> data/out_id stable, all intf_in ready low, and no beat lost or duplicated.
REQ-030 cfg_load with W={0,1,1,1} while input 0 is granted with crd=2 -> input 0 finishes its 2 remaining beats, then is never granted again.
REQ-031 rst pulsed for 1 cycle mid-stream -> next cycle intf_out.valid=0, then first grant = lowest eligible index, and W is back to all 1.

Source files
------------

// File: rtl/meta_intf_wrr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : metaIntf
//  Description : Valid/ready stream carrying one STYPE payload per beat.
//                Modport s is the receiving side, m the driving side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface metaIntf #(
  parameter type STYPE = logic [63:0]
) ();
  logic valid;
  logic ready;
  STYPE data;

  modport s (input valid, output ready, input data);
  modport m (output valid, input ready, output data);
endinterface
`default_nettype wire

// File: rtl/meta_intf_wrr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : meta_intf_wrr_scheduler
//  Description : Weighted round-robin scheduler merging N metaIntf requester
//                streams into one registered output stream. Each grant lasts
//                up to W[i] beats; one beat per cycle across grant switches.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef N_STRM_AXI
`define N_STRM_AXI 4
`endif

module meta_intf_wrr_scheduler #(
  parameter int  N_INTERFACES = `N_STRM_AXI,
  parameter type STYPE        = logic [63:0],
  parameter int  WEIGHT_BITS  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  metaIntf.s                                    intf_in [N_INTERFACES],
  metaIntf.m                                    intf_out,
  output logic [$clog2(N_INTERFACES)-1:0]       out_id,
  input  logic [N_INTERFACES*WEIGHT_BITS-1:0]   cfg_weight,
  input  logic                                  cfg_load
);

  localparam int IDW = $clog2(N_INTERFACES);
  localparam logic [IDW-1:0]         c_last_id = IDW'(N_INTERFACES - 1);
  localparam logic [IDW:0]           c_n_ext   = (IDW+1)'(N_INTERFACES);
  localparam logic [WEIGHT_BITS-1:0] c_w_one   = WEIGHT_BITS'(1);

  logic [N_INTERFACES-1:0] w_in_valid;
  logic [N_INTERFACES-1:0] w_in_ready;
  logic [N_INTERFACES-1:0] w_elig;
  STYPE                    w_in_data [N_INTERFACES];

  logic [WEIGHT_BITS-1:0]  r_weight [N_INTERFACES];
  logic [IDW-1:0]          r_cur;
  logic [WEIGHT_BITS-1:0]  r_crd;
  logic [IDW-1:0]          r_id;
  logic                    r_valid;
  STYPE                    r_data;

  logic [IDW-1:0]          w_sel;
  logic                    w_found;
  logic                    w_hold;
  logic                    w_any;
  logic                    w_free;
  logic                    w_xfer;
  logic [IDW:0]            w_sum;

  // Flatten the interface array into plain vectors; ready only goes to sel.
  for (genvar gi = 0; gi < N_INTERFACES; gi++) begin : g_in
    assign w_in_valid[gi]    = intf_in[gi].valid;
    assign w_in_data[gi]     = intf_in[gi].data;
    assign w_elig[gi]        = intf_in[gi].valid && (r_weight[gi] != '0);
    assign w_in_ready[gi]    = w_xfer && (w_sel == IDW'(gi));
    assign intf_in[gi].ready = w_in_ready[gi];
  end

  // The current holder keeps the grant while it still has credit and valid
  // data, even if its weight was zeroed meanwhile: credit already handed out
  // is honoured and the new weight only matters at the next reload.
  assign w_hold = (r_crd != '0) && w_in_valid[r_cur];
  assign w_any  = w_hold || (|w_elig);
  assign w_free = !r_valid || intf_out.ready;
  assign w_xfer = w_any && w_free && !rst;

  // Pick the next requester: keep cur while it holds credit, else scan
  // cur+1, cur+2, ... wrapping, with cur itself checked last.
  always_comb begin
    w_sel   = r_cur;
    w_found = 1'b0;
    w_sum   = '0;
    if (!w_hold) begin
      for (int k = 1; k <= N_INTERFACES; k++) begin
        w_sum = {1'b0, r_cur} + (IDW+1)'(k);
        if (w_sum >= c_n_ext) begin
          w_sum = w_sum - c_n_ext;
        end
        if (!w_found && w_elig[w_sum[IDW-1:0]]) begin
          w_sel   = w_sum[IDW-1:0];
          w_found = 1'b1;
        end
      end
    end
  end

  // Weights, grant/credit bookkeeping and output slot control.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INTERFACES; i++) begin
        r_weight[i] <= c_w_one;
      end
      r_cur   <= c_last_id;
      r_crd   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (cfg_load) begin
        for (int i = 0; i < N_INTERFACES; i++) begin
          r_weight[i] <= cfg_weight[i*WEIGHT_BITS +: WEIGHT_BITS];
        end
      end
      if (w_xfer) begin
        r_id    <= w_sel;
        r_valid <= 1'b1;
        if ((w_sel == r_cur) && (r_crd != '0)) begin
          r_crd <= r_crd - c_w_one;
        end else begin
          // Newly selected requesters are always eligible, so W[sel] >= 1.
          r_cur <= w_sel;
          r_crd <= r_weight[w_sel] - c_w_one;
        end
      end else if (intf_out.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Payload register; contents only matter while r_valid is set.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_data <= w_in_data[w_sel];
    end
  end

  assign intf_out.valid = r_valid;
  assign intf_out.data  = r_data;
  assign out_id         = r_id;

endmodule
`default_nettype wire
